bch_euclid_cell: RTL and testbench
==================================

Name:
bch_euclid_cell

Overview:
- One pipelined step of the serial Euclidean key-equation solver used in the BCH decoder, over GF(2^13).
- Coefficients of four polynomials R, Q, L, U stream in one coefficient per cycle, highest degree first. The stage optionally swaps R/Q and L/U, then cancels the leading term:
  - R' = lead(Q)·R + lead(R)·Q
  - L' = lead(Q)·L + lead(R)·U
- Cells are chained, so Rout/Qout/Lout/Uout/st_out feed the next cell's Rin/Qin/Lin/Uin/start.

Parameters:
- None.
- Field is fixed at GF(2^13), primitive polynomial p(x) = x^13 + x^4 + x^3 + x + 1.
- All data paths are 13 bits.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Rin  in  13  remainder-polynomial coefficient stream.
- Qin  in  13  divisor-polynomial coefficient stream.
- Lin  in  13  locator-polynomial coefficient stream (paired with R).
- Uin  in  13  auxiliary polynomial coefficient stream (paired with Q).
- start  in  1  high with the leading coefficient on the *in streams.
- sw  in  1  1 = swap R<->Q and L<->U; held stable for the whole polynomial.
- stop  in  1  1 = bypass: pass R/Q/L/U through without reduction.
- d1out  out  13  captured leading coefficient of the (post-swap) Q stream.
- Rout  out  13  reduced R stream.
- Qout  out  13  Q stream.
- Lout  out  13  reduced L stream.
- Uout  out  13  U stream.
- st_out  out  1  start delayed by 3 cycles.
- r_mux  out  13  post-swap R coefficient (debug/degree tracking).

Behaviour:
- Reset (reset=0, asynchronous): all 13-bit registers = 0, all start-delay flops = 0, all captured leading coefficients = 0. Combinational outputs then evaluate to 0.
- Stage 1 registers: R1, Q1, L1, U1 <= Rin, Qin, Lin, Uin. S1 <= start.
- 2:1 select rule: out = sel ? a : b.
- Swap muxes (combinational on stage 1, select = sw):
  - r_mux = sw ? Q1 : R1;  q_mux = sw ? R1 : Q1
  - l_mux = sw ? U1 : L1;  u_mux = sw ? L1 : U1
- Stage 2 registers: R2, Q2, L2, U2 <= r_mux, q_mux, l_mux, u_mux. S2 <= S1.
- Stage 3 registers: Q3 <= Q2; U3 <= U2; S3 <= S2.
- Leading-coefficient capture: four 13-bit registers, all sharing capture enable S1.
  - dq1 <= q_mux; dr2 <= r_mux; dq3 <= q_mux; dr4 <= r_mux when S1=1; otherwise hold.
  - d1out = dq1. Captured values are visible from the cycle R2/Q2 hold the leading coefficients, and stay constant for the rest of the polynomial.
- GF(2^13) multiplier: purely combinational.
  - Polynomial-basis product mod p(x); bit i = coefficient of x^i.
  - 1 is identity; 0 is annihilator; commutative.
- Datapath:
  - add1 = (R2 ⊗ dq1) ^ (dr2 ⊗ Q2)
  - add2 = (L2 ⊗ dq3) ^ (dr4 ⊗ U2)
  - Addition is XOR.
- Output muxes (select = stop):
  - Rout = stop ? R2 : add1;  Qout = stop ? Q2 : Q3
  - Lout = stop ? L2 : add2;  Uout = stop ? U2 : U3
- st_out = S3.
- Latency:
  - Rout/Lout reflect input from 2 edges earlier.
  - Qout/Uout reflect input from 3 edges earlier when stop=0, 2 when stop=1.
  - With stop=0, the cancelled (zero) leading term of Rout coincides with S2. st_out therefore marks the next coefficient, so the degree drops by one.
- A new start pulse re-captures the leading coefficients on the next edge. Back-to-back polynomials are allowed.
- Reset mid-stream: clears the pipeline immediately. Captured coefficients become 0, so Rout = Lout = 0 until the next start.

Test Plan:
1. Assert reset=0 with arbitrary inputs -> all outputs 0x0000, st_out=0. Release reset -> outputs follow pipeline latency.
2. stop=1, sw=0, Rin=0x0005, Qin=0x0007, Lin=0x0009, Uin=0x000B at cycle 0 -> after 2 edges Rout=0x0005, Qout=0x0007, Lout=0x0009, Uout=0x000B. r_mux=0x0005 after 1 edge.
3. sw=1, Rin=0x0011, Qin=0x0022 -> after 1 edge r_mux=0x0022. After 2 edges with stop=1: Rout=0x0022, Qout=0x0011.
4. Multiplier check via datapath: α^12 ⊗ α (0x1000 ⊗ 0x0002) = 0x001B; 0x1FFF ⊗ 0x0001 = 0x1FFF; x ⊗ 0 = 0.
5. stop=0, sw=0. Cycle 0: start=1, Rin=1, Qin=1, Lin=1, Uin=0. Cycle 1: start=0, Rin=2, Qin=3, Lin=0, Uin=1.
   - After edge 2: d1out=1, Rout=0, Lout=1.
   - After edge 3: Rout=0x0001 (2^3), Lout=0x0001, Qout=0x0001, st_out=1 for exactly one cycle.
6. Second start pulse with new leading coefficients (Rin=0x0004, Qin=0x0002) -> d1out updates to 0x0002 one edge after the pulse and holds until the next start.

Source files
------------

// File: rtl/bch_euclid_cell_if.sv
// Coefficient-stream bundle for one Euclidean key-equation cell.
//
// Ports / signals:
//   Rin, Qin, Lin, Uin  13-bit coefficient streams entering the cell
//   start               marks the leading coefficient on the *in streams
//   sw                  swap R<->Q and L<->U for the current polynomial
//   stop                bypass: pass the streams through unreduced
//   d1out               captured leading coefficient of the post-swap Q stream
//   Rout, Qout          reduced R stream and delayed Q stream
//   Lout, Uout          reduced L stream and delayed U stream
//   st_out              start delayed by three cycles
//   r_mux               post-swap R coefficient in the first stage
//
// The slave modport is the cell; the master modport is whatever feeds it.
interface bch_euclid_cell_if;
  logic [12:0] Rin;
  logic [12:0] Qin;
  logic [12:0] Lin;
  logic [12:0] Uin;
  logic        start;
  logic        sw;
  logic        stop;
  logic [12:0] d1out;
  logic [12:0] Rout;
  logic [12:0] Qout;
  logic [12:0] Lout;
  logic [12:0] Uout;
  logic        st_out;
  logic [12:0] r_mux;

  modport master (
    output Rin, Qin, Lin, Uin, start, sw, stop,
    input  d1out, Rout, Qout, Lout, Uout, st_out, r_mux
  );

  modport slave (
    input  Rin, Qin, Lin, Uin, start, sw, stop,
    output d1out, Rout, Qout, Lout, Uout, st_out, r_mux
  );
endinterface

// File: rtl/bch_euclid_cell.sv
// One pipelined step of the serial Euclidean key-equation solver over
// GF(2^13), p(x) = x^13 + x^4 + x^3 + x + 1.
//
// Coefficients of R, Q, L, U arrive one per cycle, highest degree first.
// The cell optionally swaps R/Q and L/U, captures the leading coefficients
// when start is seen, and cancels the leading term:
//   R' = lead(Q)*R + lead(R)*Q
//   L' = lead(Q)*L + lead(R)*U
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    coefficient streams and results (slave side of bch_euclid_cell_if)
module bch_euclid_cell (
  input  logic                clk,
  input  logic                reset,
  bch_euclid_cell_if.slave    bus
);

  logic [12:0] r1, q1, l1, u1;
  logic [12:0] r2, q2, l2, u2;
  logic [12:0] q3, u3;
  logic        s1, s2, s3;
  logic [12:0] dq1, dr2, dq3, dr4;
  logic [12:0] r_sel, q_sel, l_sel, u_sel;
  logic [12:0] add1, add2;

  // Polynomial-basis multiply, MSB-first Horner form: shift the accumulator
  // by x and fold the overflowing x^13 back in as x^4 + x^3 + x + 1.
  function automatic logic [12:0] gf_mul(input logic [12:0] a, input logic [12:0] b);
    logic [12:0] acc;
    acc = '0;
    for (int i = 12; i >= 0; i--) begin
      acc = {acc[11:0], 1'b0} ^ (acc[12] ? 13'h001B : 13'h0000);
      if (b[i]) acc = acc ^ a;
    end
    return acc;
  endfunction

  // Swap muxes act on the first pipeline stage.
  assign r_sel = bus.sw ? q1 : r1;
  assign q_sel = bus.sw ? r1 : q1;
  assign l_sel = bus.sw ? u1 : l1;
  assign u_sel = bus.sw ? l1 : u1;

  // Three-stage coefficient pipeline plus leading-coefficient capture.
  // The capture uses S1 so the leads are already stable while the leading
  // coefficients themselves sit in stage 2, which is what makes the
  // leading term of add1 cancel to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r1  <= '0; q1 <= '0; l1 <= '0; u1 <= '0;
      r2  <= '0; q2 <= '0; l2 <= '0; u2 <= '0;
      q3  <= '0; u3 <= '0;
      s1  <= 1'b0; s2 <= 1'b0; s3 <= 1'b0;
      dq1 <= '0; dr2 <= '0; dq3 <= '0; dr4 <= '0;
    end else begin
      r1 <= bus.Rin;
      q1 <= bus.Qin;
      l1 <= bus.Lin;
      u1 <= bus.Uin;
      s1 <= bus.start;
      r2 <= r_sel;
      q2 <= q_sel;
      l2 <= l_sel;
      u2 <= u_sel;
      s2 <= s1;
      q3 <= q2;
      u3 <= u2;
      s3 <= s2;
      if (s1) begin
        dq1 <= q_sel;
        dr2 <= r_sel;
        dq3 <= q_sel;
        dr4 <= r_sel;
      end
    end
  end

  assign add1 = gf_mul(r2, dq1) ^ gf_mul(dr2, q2);
  assign add2 = gf_mul(l2, dq3) ^ gf_mul(dr4, u2);

  // In bypass the Q/U streams skip their extra stage so all four outputs
  // stay aligned with the unreduced R/L streams.
  assign bus.Rout   = bus.stop ? r2 : add1;
  assign bus.Qout   = bus.stop ? q2 : q3;
  assign bus.Lout   = bus.stop ? l2 : add2;
  assign bus.Uout   = bus.stop ? u2 : u3;
  assign bus.st_out = s3;
  assign bus.d1out  = dq1;
  assign bus.r_mux  = r_sel;

endmodule

// File: tb/tb_bch_euclid_cell.sv
// Self-checking bench for bch_euclid_cell: reset checks, a table of
// directed vectors, a mid-stream reset sequence and a randomized run
// compared against a coefficient-level reference model.
module tb_bch_euclid_cell;

  localparam int NRAND = 700;

  typedef struct {
    logic [12:0] rin, qin, lin, uin;
    logic        start, sw, stop;
    logic [6:0]  mask;   // 0 Rout 1 Qout 2 Lout 3 Uout 4 st_out 5 r_mux 6 d1out
    logic [12:0] rout, qout, lout, uout, rmux, d1;
    logic        st;
  } vec_t;

  typedef struct {
    logic [12:0] r, q, l, u;
    logic        start, sw, stop;
  } stim_t;

  typedef struct {
    logic [12:0] r, q, l, u;
  } quad_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  vec_t  vecs[17];
  stim_t hist[NRAND];

  bch_euclid_cell_if bus();

  bch_euclid_cell dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference multiply: full carry-less product, then reduce from the top.
  function automatic logic [12:0] gf_ref(input logic [12:0] a, input logic [12:0] b);
    logic [24:0] prod;
    prod = '0;
    for (int i = 0; i < 13; i++)
      if (b[i]) prod = prod ^ (25'(a) << i);
    for (int i = 24; i >= 13; i--)
      if (prod[i]) prod = prod ^ (25'h000201B << (i - 13));
    return prod[12:0];
  endfunction

  function automatic vec_t mk(input logic [12:0] rin, qin, lin, uin,
                              input logic start, sw, stop, input logic [6:0] mask,
                              input logic [12:0] rout, qout, lout, uout, rmux, d1,
                              input logic st);
    vec_t v;
    v.rin = rin; v.qin = qin; v.lin = lin; v.uin = uin;
    v.start = start; v.sw = sw; v.stop = stop; v.mask = mask;
    v.rout = rout; v.qout = qout; v.lout = lout; v.uout = uout;
    v.rmux = rmux; v.d1 = d1; v.st = st;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [12:0] r, q, l, u, input logic start, sw, stop);
    bus.Rin = r; bus.Qin = q; bus.Lin = l; bus.Uin = u;
    bus.start = start; bus.sw = sw; bus.stop = stop;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Coefficient idx after the swap that is applied while it is in stage 1
  // and the swap control of cycle swidx is being driven.
  function automatic quad_t swapped(input int idx, input int swidx);
    quad_t o;
    logic  w;
    o = '{default: '0};
    if (idx < 0) return o;
    w = (swidx < 0) ? 1'b0 : hist[swidx].sw;
    o.r = w ? hist[idx].q : hist[idx].r;
    o.q = w ? hist[idx].r : hist[idx].q;
    o.l = w ? hist[idx].u : hist[idx].l;
    o.u = w ? hist[idx].l : hist[idx].u;
    return o;
  endfunction

  task automatic check_model(input int k);
    quad_t rm, s2, s3, ld;
    logic  stp, st_exp;
    rm = swapped(k, k);
    s2 = swapped(k - 1, k);
    s3 = swapped(k - 2, k - 1);
    ld = '{default: '0};
    for (int j = k - 1; j >= 0; j--) begin
      if (hist[j].start) begin
        ld = swapped(j, j + 1);
        break;
      end
    end
    st_exp = (k >= 2) ? hist[k - 2].start : 1'b0;
    stp = hist[k].stop;
    check_output($sformatf("rand%0d Rout", k), bus.Rout,
                 stp ? s2.r : gf_ref(s2.r, ld.q) ^ gf_ref(ld.r, s2.q));
    check_output($sformatf("rand%0d Qout", k), bus.Qout, stp ? s2.q : s3.q);
    check_output($sformatf("rand%0d Lout", k), bus.Lout,
                 stp ? s2.l : gf_ref(s2.l, ld.q) ^ gf_ref(ld.r, s2.u));
    check_output($sformatf("rand%0d Uout", k), bus.Uout, stp ? s2.u : s3.u);
    check_output($sformatf("rand%0d r_mux", k), bus.r_mux, rm.r);
    check_output($sformatf("rand%0d d1out", k), bus.d1out, ld.q);
    check_output($sformatf("rand%0d st_out", k), 13'(bus.st_out), 13'(st_exp));
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, " Rout"}, bus.Rout, 13'h0);
    check_output({tag, " Qout"}, bus.Qout, 13'h0);
    check_output({tag, " Lout"}, bus.Lout, 13'h0);
    check_output({tag, " Uout"}, bus.Uout, 13'h0);
    check_output({tag, " r_mux"}, bus.r_mux, 13'h0);
    check_output({tag, " d1out"}, bus.d1out, 13'h0);
    check_output({tag, " st_out"}, 13'(bus.st_out), 13'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;

    vecs[0]  = mk(13'h5, 13'h7, 13'h9, 13'hB, 0, 0, 1, 7'b0110001, 13'h0, 0, 0, 0, 13'h5, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 1, 7'b0001111, 13'h5, 13'h7, 13'h9, 13'hB, 0, 0, 0);
    vecs[2]  = mk(13'h11, 13'h22, 0, 0, 0, 1, 1, 7'b0100001, 13'h0, 0, 0, 0, 13'h22, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 1, 1, 7'b0100011, 13'h22, 13'h11, 0, 0, 13'h0, 0, 0);
    vecs[4]  = mk(0, 13'h2, 0, 0, 1, 0, 0, 7'b0010000, 0, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(13'h1000, 0, 13'h1FFF, 0, 0, 0, 0, 7'b1000001, 13'h0, 0, 0, 0, 0, 13'h2, 0);
    vecs[6]  = mk(0, 13'h1, 0, 0, 1, 0, 0, 7'b0010111, 13'h1B, 13'h2, 13'h1FE5, 0, 0, 0, 1);
    vecs[7]  = mk(13'h1FFF, 0, 0, 0, 0, 0, 0, 7'b1010001, 13'h0, 0, 0, 0, 0, 13'h1, 0);
    vecs[8]  = mk(13'h1ABC, 13'h1, 0, 13'h155, 1, 0, 0, 7'b0010001, 13'h1FFF, 0, 0, 0, 0, 0, 1);
    vecs[9]  = mk(0, 0, 13'h123, 13'h777, 0, 0, 0, 7'b1000001, 13'h0, 0, 0, 0, 0, 13'h1, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 7'b0010001, 13'h0, 0, 0, 0, 0, 0, 1);
    vecs[11] = mk(13'h1, 13'h1, 13'h1, 0, 1, 0, 0, 7'b0010000, 0, 0, 0, 0, 0, 0, 0);
    vecs[12] = mk(13'h2, 13'h3, 0, 13'h1, 0, 0, 0, 7'b1010101, 13'h0, 0, 13'h1, 0, 0, 13'h1, 0);
    vecs[13] = mk(13'h4, 13'h2, 0, 0, 1, 0, 0, 7'b1010111, 13'h1, 13'h1, 13'h1, 0, 0, 13'h1, 1);
    vecs[14] = mk(13'h3, 13'h5, 0, 0, 0, 0, 0, 7'b1010001, 13'h0, 0, 0, 0, 0, 13'h2, 0);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 7'b1010001, 13'h12, 0, 0, 0, 0, 13'h2, 1);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 7'b1010000, 0, 0, 0, 0, 0, 13'h2, 0);

    // Reset with busy, arbitrary inputs: everything must read zero.
    reset = 1'b0;
    apply_stimulus(13'h1ABC, 13'h0F0F, 13'h1234, 13'h0555, 1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    check_all_zero("reset");
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;

    // Directed table.
    for (int i = 0; i < 17; i++) begin
      apply_stimulus(vecs[i].rin, vecs[i].qin, vecs[i].lin, vecs[i].uin,
                     vecs[i].start, vecs[i].sw, vecs[i].stop);
      tick();
      if (vecs[i].mask[0]) check_output($sformatf("vec%0d Rout", i), bus.Rout, vecs[i].rout);
      if (vecs[i].mask[1]) check_output($sformatf("vec%0d Qout", i), bus.Qout, vecs[i].qout);
      if (vecs[i].mask[2]) check_output($sformatf("vec%0d Lout", i), bus.Lout, vecs[i].lout);
      if (vecs[i].mask[3]) check_output($sformatf("vec%0d Uout", i), bus.Uout, vecs[i].uout);
      if (vecs[i].mask[4]) check_output($sformatf("vec%0d st_out", i), 13'(bus.st_out), 13'(vecs[i].st));
      if (vecs[i].mask[5]) check_output($sformatf("vec%0d r_mux", i), bus.r_mux, vecs[i].rmux);
      if (vecs[i].mask[6]) check_output($sformatf("vec%0d d1out", i), bus.d1out, vecs[i].d1);
    end

    // Mid-stream reset: the pipeline and leads clear without a clock edge,
    // and reduction yields zero until a fresh start.
    apply_stimulus(13'h7, 13'h9, 13'h3, 13'h5, 1, 0, 0);
    tick();
    apply_stimulus(13'h100, 13'h55, 13'h77, 13'h33, 0, 0, 0);
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    check_output("midrst Rout", bus.Rout, 13'h0);
    check_output("midrst Qout", bus.Qout, 13'h0);
    check_output("midrst Lout", bus.Lout, 13'h0);
    check_output("midrst Uout", bus.Uout, 13'h0);
    check_output("midrst d1out", bus.d1out, 13'h0);
    tick();
    reset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_output($sformatf("postrst%0d Rout", i), bus.Rout, 13'h0);
      check_output($sformatf("postrst%0d Lout", i), bus.Lout, 13'h0);
      check_output($sformatf("postrst%0d d1out", i), bus.d1out, 13'h0);
    end
    check_output("postrst Qout", bus.Qout, 13'h55);
    check_output("postrst Uout", bus.Uout, 13'h33);

    // Randomized run from a clean reset against the reference model.
    reset = 1'b0;
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    begin
      logic cur_sw, cur_stop;
      cur_sw = 1'b0;
      cur_stop = 1'b0;
      for (int k = 0; k < NRAND; k++) begin
        hist[k].start = ($urandom_range(0, 5) == 0);
        if (hist[k].start) begin
          cur_sw = 1'($urandom_range(0, 1));
          cur_stop = ($urandom_range(0, 3) == 0);
        end
        hist[k].sw = cur_sw;
        hist[k].stop = cur_stop;
        hist[k].r = ($urandom_range(0, 7) == 0) ? 13'h0 : 13'($urandom);
        hist[k].q = ($urandom_range(0, 7) == 0) ? 13'h0 : 13'($urandom);
        hist[k].l = 13'($urandom);
        hist[k].u = 13'($urandom);
        apply_stimulus(hist[k].r, hist[k].q, hist[k].l, hist[k].u,
                       hist[k].start, hist[k].sw, hist[k].stop);
        tick();
        check_model(k);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
